// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell + borrow flop.
// Ports: clk, rst_n, start, a, b, bin -> diff, bout, ovf, busy, done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             brw_next;
    logic             x;
    logic             y;
    logic             d;
    logic             accept;
    logic             last;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    assign x        = a_sh[0];
    assign y        = b_sh[0];
    assign d        = x ^ y ^ brw;
    assign brw_next = (~x & y) | (~(x ^ y) & brw);

    generate
        if (WIDTH == 1) begin : g_r1
            assign r_next = d;
        end else begin : g_rn
            assign r_next = {d, r_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (accept) begin
                a_sh <= a;
                b_sh <= b;
                brw  <= bin;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                r_sh <= r_next;
                brw  <= brw_next;
                cnt  <= cnt + CW'(1);
            end
            // On the last bit x/y are the operand MSBs and d is the result MSB.
            if (last) begin
                diff <= r_next;
                bout <= brw_next;
                ovf  <= (x ^ y) & (d ^ x);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
// Each task drives one scenario and checks its own expectations inline.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic [7:0] diff;
    logic       bout, ovf, busy, done;

    logic       s1_start = 1'b0;
    logic [0:0] s1_a = '0;
    logic [0:0] s1_b = '0;
    logic       s1_bin = 1'b0;
    logic [0:0] s1_diff;
    logic       s1_bout, s1_ovf, s1_busy, s1_done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .diff(diff), .bout(bout), .ovf(ovf), .busy(busy), .done(done)
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b),
        .bin(s1_bin), .diff(s1_diff), .bout(s1_bout), .ovf(s1_ovf),
        .busy(s1_busy), .done(s1_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for cycle 0; returns 1ns into cycle 1.
    task automatic launch(input logic [7:0] va, input logic [7:0] vb,
                          input logic vbin);
        a = va;
        b = vb;
        bin = vbin;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({diff, bout, ovf, busy, done} !== 12'h000)
            $display("FAIL reset8 got diff=%h bout=%b ovf=%b busy=%b done=%b want all 0",
                     diff, bout, ovf, busy, done);
        else passed++;
        total++;
        if ({s1_diff, s1_bout, s1_ovf, s1_busy, s1_done} !== 5'b0)
            $display("FAIL reset1 got %b want 00000",
                     {s1_diff, s1_bout, s1_ovf, s1_busy, s1_done});
        else passed++;
    endtask

    task automatic test_basic();
        int busy_cycles;
        int bad;
        busy_cycles = 0;
        bad = 0;
        launch(8'h5A, 8'h3C, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            if (busy === 1'b1) busy_cycles++;
            if (done !== 1'b0) bad++;
            if (c < 8) tick();
        end
        total++;
        if (busy_cycles != 8 || bad != 0)
            $display("FAIL busy_window got busy=%0d done_hits=%0d want 8/0",
                     busy_cycles, bad);
        else passed++;
        tick();
        total++;
        if ({done, busy} !== 2'b10)
            $display("FAIL done_cycle9 got done=%b busy=%b want 1/0", done, busy);
        else passed++;
        total++;
        if ({diff, bout, ovf} !== {8'h1E, 1'b0, 1'b0})
            $display("FAIL basic_5A_3C got %h/%b/%b want 1e/0/0", diff, bout, ovf);
        else passed++;
        tick();
        total++;
        if ({done, busy, diff} !== {1'b0, 1'b0, 8'h1E})
            $display("FAIL after_done got done=%b busy=%b diff=%h want 0/0/1e",
                     done, busy, diff);
        else passed++;
    endtask

    task automatic test_vectors();
        logic [7:0] va [5];
        logic [7:0] vb [5];
        logic       vc [5];
        logic [9:0] exp [5];
        va = '{8'h00, 8'h80, 8'h10, 8'h00, 8'h7F};
        vb = '{8'h01, 8'h01, 8'h0F, 8'hFF, 8'h80};
        vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp = '{{8'hFF, 1'b1, 1'b0}, {8'h7F, 1'b0, 1'b1},
                {8'h00, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b0},
                {8'hFF, 1'b1, 1'b1}};
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i], vc[i]);
            repeat (8) tick();
            total++;
            if ({done, diff, bout, ovf} !== {1'b1, exp[i]})
                $display("FAIL vec%0d got done=%b %h/%b/%b want 1 %h/%b/%b",
                         i, done, diff, bout, ovf,
                         exp[i][9:2], exp[i][1], exp[i][0]);
            else passed++;
            tick();
        end
    endtask

    // Ends in the DONE cycle of the first op.
    task automatic test_start_in_run();
        launch(8'h5A, 8'h3C, 1'b0);
        repeat (3) tick();
        a = 8'hFF;
        b = 8'h00;
        bin = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || diff !== 8'hFF)
            $display("FAIL run_hold got busy=%b diff=%h want 1/ff", busy, diff);
        else passed++;
        repeat (4) tick();
        total++;
        if ({done, diff, bout, ovf} !== {1'b1, 8'h1E, 1'b0, 1'b0})
            $display("FAIL start_ignored got done=%b %h/%b/%b want 1 1e/0/0",
                     done, diff, bout, ovf);
        else passed++;
    endtask

    task automatic test_back_to_back();
        launch(8'h80, 8'h01, 1'b0);
        total++;
        if ({busy, done, diff} !== {1'b1, 1'b0, 8'h1E})
            $display("FAIL b2b_run got busy=%b done=%b diff=%h want 1/0/1e",
                     busy, done, diff);
        else passed++;
        repeat (7) tick();
        total++;
        if ({busy, done} !== 2'b10)
            $display("FAIL b2b_c8 got busy=%b done=%b want 1/0", busy, done);
        else passed++;
        tick();
        total++;
        if ({done, diff, bout, ovf} !== {1'b1, 8'h7F, 1'b0, 1'b1})
            $display("FAIL b2b_result got done=%b %h/%b/%b want 1 7f/0/1",
                     done, diff, bout, ovf);
        else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        int done_hits;
        done_hits = 0;
        launch(8'h5A, 8'h3C, 1'b0);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({diff, bout, ovf, busy, done} !== 12'h000)
            $display("FAIL async_rst got diff=%h bout=%b ovf=%b busy=%b done=%b want 0",
                     diff, bout, ovf, busy, done);
        else passed++;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) done_hits++;
        end
        total++;
        if (done_hits != 0)
            $display("FAIL no_done_after_abort got %0d bad cycles want 0", done_hits);
        else passed++;
        launch(8'h00, 8'h01, 1'b0);
        repeat (8) tick();
        total++;
        if ({done, diff, bout, ovf} !== {1'b1, 8'hFF, 1'b1, 1'b0})
            $display("FAIL post_rst_op got done=%b %h/%b/%b want 1 ff/1/0",
                     done, diff, bout, ovf);
        else passed++;
        tick();
    endtask

    task automatic test_width1();
        s1_a = 1'b1;
        s1_b = 1'b1;
        s1_bin = 1'b1;
        s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        total++;
        if ({s1_busy, s1_done} !== 2'b10)
            $display("FAIL w1_c1 got busy=%b done=%b want 1/0", s1_busy, s1_done);
        else passed++;
        tick();
        total++;
        if ({s1_done, s1_busy, s1_diff, s1_bout, s1_ovf} !== 5'b10110)
            $display("FAIL w1_result got done=%b busy=%b %b/%b/%b want 1/0 1/1/0",
                     s1_done, s1_busy, s1_diff, s1_bout, s1_ovf);
        else passed++;
        tick();
        total++;
        if (s1_done !== 1'b0)
            $display("FAIL w1_pulse got done=%b want 0", s1_done);
        else passed++;
    endtask

    initial begin
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_vectors();
        test_start_in_run();
        test_back_to_back();
        test_async_reset();
        test_width1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
